updown_step_counter: RTL and testbench

UPDOWN_STEP_COUNTER -- requirements
Module: updown_step_counter

---
 rtl/updown_step_counter.sv | 97 +++++++++
 tb/tb_updown_step_counter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/updown_step_counter.sv
// Up/down step counter over the range 0..MAX with wrap or saturate at the
// bounds, optional rising-edge detection on step, and registered parity,
// Gray-code, terminal-count and at-bound flags that all move with count.
module updown_step_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15,
  parameter int SAT   = 0,
  parameter int EDGE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             dir,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             out,
  output logic [WIDTH-1:0] gray,
  output logic             tc,
  output logic             at_bound
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZERO  = '0;

  logic             step_q;
  logic             adv;
  logic [WIDTH-1:0] next_count;
  logic             next_tc;

  // step_q tracks step every cycle so a rise coinciding with clear or load is
  // consumed and cannot advance on a later cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  // Advance request: plain enable, or rising edge of a level when EDGE=1.
  always_comb begin
    adv = (EDGE != 0) ? (step & ~step_q) : step;
  end

  // Next count and terminal pulse, priority clear > load > adv > hold.
  // NOTE: every output of this block gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_count = count;
    next_tc    = 1'b0;
    if (clear) begin
      next_count = ZERO;
    end else if (load) begin
      next_count = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (adv) begin
      if (dir) begin
        if (count >= MAX_V) begin
          next_count = (SAT != 0) ? MAX_V : ZERO;
          next_tc    = 1'b1;
        end else begin
          next_count = count + 1'b1;
        end
      end else begin
        if (count == ZERO) begin
          next_count = (SAT != 0) ? ZERO : MAX_V;
          next_tc    = 1'b1;
        end else begin
          next_count = count - 1'b1;
        end
      end
    end
  end

  // Count and all derived flags register from next_count on the same edge.
  // NOTE: reset is asynchronous and clears every register of the block;
  // at_bound resets high because count resets to the lower bound.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= ZERO;
      out      <= 1'b0;
      gray     <= ZERO;
      tc       <= 1'b0;
      at_bound <= 1'b1;
    end else begin
      count    <= next_count;
      out      <= next_count[0];
      gray     <= next_count ^ (next_count >> 1);
      tc       <= next_tc;
      at_bound <= (next_count == ZERO) || (next_count == MAX_V);
    end
  end

endmodule

// File: tb/tb_updown_step_counter.sv
// Directed bench for updown_step_counter: three instances (defaults,
// saturating MAX=9, edge-detect) share the same stimulus; each phase checks
// the instance whose behaviour it targets against hand-computed values.
module tb_updown_step_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       step;
  logic       dir;
  logic       clear;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] d_count, s_count, e_count;
  logic [3:0] d_gray,  s_gray,  e_gray;
  logic       d_out,   s_out,   e_out;
  logic       d_tc,    s_tc,    e_tc;
  logic       d_bnd,   s_bnd,   e_bnd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  updown_step_counter dut_def (
    .clk(clk), .reset(reset), .step(step), .dir(dir), .clear(clear),
    .load(load), .load_val(load_val), .count(d_count), .out(d_out),
    .gray(d_gray), .tc(d_tc), .at_bound(d_bnd)
  );

  updown_step_counter #(.WIDTH(4), .MAX(9), .SAT(1), .EDGE(0)) dut_sat (
    .clk(clk), .reset(reset), .step(step), .dir(dir), .clear(clear),
    .load(load), .load_val(load_val), .count(s_count), .out(s_out),
    .gray(s_gray), .tc(s_tc), .at_bound(s_bnd)
  );

  updown_step_counter #(.WIDTH(4), .MAX(15), .SAT(0), .EDGE(1)) dut_edge (
    .clk(clk), .reset(reset), .step(step), .dir(dir), .clear(clear),
    .load(load), .load_val(load_val), .count(e_count), .out(e_out),
    .gray(e_gray), .tc(e_tc), .at_bound(e_bnd)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_c;

    reset = 1'b1; step = 1'b0; dir = 1'b1; clear = 1'b0;
    load = 1'b0; load_val = 4'd0;
    #2;
    check("rst_count", d_count, 0);
    check("rst_out",   d_out,   0);
    check("rst_gray",  d_gray,  0);
    check("rst_tc",    d_tc,    0);
    check("rst_bound", d_bnd,   1);
    check("rst_sat_bound", s_bnd, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    // 16 steps up from reset: 1..15 then wrap to 0 with tc.
    dir = 1'b1; step = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cycle();
      exp_c = 4'(i % 16);
      check($sformatf("up_count_%0d", i), d_count, exp_c);
      check($sformatf("up_tc_%0d", i), d_tc, (i == 16) ? 1 : 0);
      check($sformatf("up_out_%0d", i), d_out, exp_c[0]);
    end
    step = 1'b0;

    // Hold with no request.
    cycle();
    check("hold_count", d_count, 0);
    check("hold_tc",    d_tc,    0);

    // One step down from 0 wraps to 15.
    dir = 1'b0; step = 1'b1;
    cycle();
    check("dn_wrap_count", d_count, 15);
    check("dn_wrap_gray",  d_gray,  4'b1000);
    check("dn_wrap_tc",    d_tc,    1);
    check("dn_wrap_bound", d_bnd,   1);
    cycle();
    check("dn_14_count", d_count, 14);
    check("dn_14_gray",  d_gray,  4'b1001);
    check("dn_14_tc",    d_tc,    0);
    check("dn_14_bound", d_bnd,   0);
    step = 1'b0;

    // Saturating instance: load clamps to MAX, up holds with tc, down moves.
    load = 1'b1; load_val = 4'd12;
    cycle();
    check("sat_load_count", s_count, 9);
    check("sat_load_tc",    s_tc,    0);
    check("sat_load_bound", s_bnd,   1);
    check("def_load_count", d_count, 12);
    load = 1'b0; dir = 1'b1; step = 1'b1;
    cycle();
    check("sat_up_count", s_count, 9);
    check("sat_up_tc",    s_tc,    1);
    dir = 1'b0;
    cycle();
    check("sat_dn_count", s_count, 8);
    check("sat_dn_tc",    s_tc,    0);
    check("sat_dn_bound", s_bnd,   0);
    step = 1'b0;

    // clear beats load and step.
    load = 1'b1; load_val = 4'd7;
    cycle();
    check("ld7_count", d_count, 7);
    clear = 1'b1; load = 1'b1; load_val = 4'd5; step = 1'b1; dir = 1'b1;
    cycle();
    check("clr_count", d_count, 0);
    check("clr_tc",    d_tc,    0);
    check("clr_bound", d_bnd,   1);
    // load beats step.
    clear = 1'b0; load = 1'b1; load_val = 4'd3;
    cycle();
    check("ld_pri_count", d_count, 3);
    check("ld_pri_tc",    d_tc,    0);

    // Edge mode: level held 5 cycles advances exactly once.
    step = 1'b0; load = 1'b1; load_val = 4'd3;
    cycle();
    check("edge_ld_count", e_count, 3);
    load = 1'b0; dir = 1'b1; step = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      check($sformatf("edge_hold_%0d", i), e_count, 4);
      check($sformatf("edge_tc_%0d", i), e_tc, 0);
    end
    step = 1'b0;
    cycle();
    check("edge_release", e_count, 4);

    // Edge mode: rise coinciding with load is consumed.
    load = 1'b1; load_val = 4'd10; step = 1'b1;
    cycle();
    check("edge_ld10_count", e_count, 10);
    load = 1'b0;
    cycle();
    check("edge_consumed", e_count, 10);
    step = 1'b0;

    // Asynchronous reset between edges at count 6.
    load = 1'b1; load_val = 4'd6;
    cycle();
    check("pre_rst_count", d_count, 6);
    load = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("arst_count", d_count, 0);
    check("arst_bound", d_bnd,   1);
    check("arst_gray",  d_gray,  0);
    check("arst_out",   d_out,   0);
    #1 reset = 1'b0;

    // First advance after reset starts from 0.
    dir = 1'b1; step = 1'b1;
    cycle();
    check("post_rst_def",  d_count, 1);
    check("post_rst_edge", e_count, 1);
    check("post_rst_sat",  s_count, 1);
    step = 1'b0;

    // Saturating down at 0 holds with tc.
    clear = 1'b1;
    cycle();
    clear = 1'b0; dir = 1'b0; step = 1'b1;
    cycle();
    check("sat_lo_count", s_count, 0);
    check("sat_lo_tc",    s_tc,    1);
    check("sat_lo_bound", s_bnd,   1);
    step = 1'b0;
    cycle();
    check("sat_lo_tc_drop", s_tc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
